imem_responder: RTL and testbench

//   Instruction-memory responder for the fetch stage. Holds a word-addressed

---
 rtl/imem_responder.sv | 199 +++++++++++++++++++
 tb/tb_imem_responder.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_responder.sv
// -----------------------------------------------------------------------------
// imem_responder
//
// Instruction-memory responder for the fetch stage. It holds a word-addressed
// instruction RAM and fills it from a streaming load port after reset, or on a
// reload. Once the image is loaded, it answers fetch requests one cycle after
// acceptance.
//
// Misaligned and out-of-range fetches return NOP_INSTR with resp_fault_o set.
// A flush in the same cycle as an accepted request squashes that request's
// response.
//
// State sequence: IDLE --load_start--> LOAD --last word--> RUN --load_start--> LOAD
//
// Ports
//   clk            clock
//   rst            asynchronous, active-high reset
//   req_valid_i    fetch request present
//   req_ready_o    requests accepted (RUN only)
//   req_addr_i     fetch byte address
//   flush_i        squash the request presented this cycle
//   resp_valid_o   response valid this cycle
//   resp_instr_o   fetched instruction, or NOP_INSTR on fault
//   resp_fault_o   misaligned or out-of-range fetch
//   load_start_i   begin (re)load at word 0 (honoured in IDLE and RUN)
//   load_valid_i   load word present
//   load_ready_o   load word accepted (LOAD only)
//   load_data_i    instruction word to write
//   load_last_i    final word of the image
//   load_busy_o    high in IDLE and LOAD
// -----------------------------------------------------------------------------
module imem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_addr_i,
  input  logic        flush_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_instr_o,
  output logic        resp_fault_o,
  input  logic        load_start_i,
  input  logic        load_valid_i,
  output logic        load_ready_o,
  input  logic [31:0] load_data_i,
  input  logic        load_last_i,
  output logic        load_busy_o
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  // The pointer carries one extra bit so it can sit at DEPTH_WORDS without
  // wrapping back onto word 0.
  localparam int unsigned PTR_W = IDX_W + 1;
  // Span in bytes, 33 bits wide so that the largest legal depth still fits.
  localparam logic [32:0] SPAN_BYTES = 33'(DEPTH_WORDS) << 2;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH_WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t             state_q;
  logic [PTR_W-1:0]   ptr_q;
  logic               req_ready_q;
  logic               load_ready_q;
  logic               load_busy_q;

  logic [31:0]        mem_q [DEPTH_WORDS];

  logic               resp_valid_q;
  logic               resp_fault_q;
  logic [31:0]        resp_instr_q;
  logic               resp_valid_d;

  logic [31:0]        offset_s;
  logic [IDX_W-1:0]   idx_s;
  logic               misaligned_s;
  logic               out_of_range_s;
  logic               fault_s;
  logic               req_accept_s;
  logic               load_accept_s;
  logic               load_done_s;

  // Unsigned wrap-around subtraction: addresses below BASE_ADDR become huge
  // offsets, so a single range compare covers both ends.
  assign offset_s       = req_addr_i - BASE_ADDR;
  assign idx_s          = offset_s[IDX_W+1:2];
  assign misaligned_s   = (req_addr_i[1:0] != 2'b00);
  assign out_of_range_s = ({1'b0, offset_s} >= SPAN_BYTES);
  assign fault_s        = misaligned_s | out_of_range_s;

  assign req_accept_s   = req_valid_i & req_ready_q;
  assign load_accept_s  = load_valid_i & load_ready_q;
  assign load_done_s    = load_last_i | (ptr_q == LAST_IDX);

  // Next response-valid: an accepted request that is not squashed by flush.
  always_comb begin
    resp_valid_d = 1'b0;
    if (req_accept_s && !flush_i) begin
      resp_valid_d = 1'b1;
    end else begin
      resp_valid_d = 1'b0;
    end
  end

  // Control FSM, including the load pointer and the registered handshake and
  // busy outputs. The outputs are set on the same edge as the state change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      req_ready_q  <= 1'b0;
      load_ready_q <= 1'b0;
      load_busy_q  <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (load_start_i) begin
            state_q      <= ST_LOAD;
            ptr_q        <= '0;
            load_ready_q <= 1'b1;
            req_ready_q  <= 1'b0;
            load_busy_q  <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (load_accept_s) begin
            ptr_q <= ptr_q + PTR_W'(1);
            if (load_done_s) begin
              state_q      <= ST_RUN;
              load_ready_q <= 1'b0;
              req_ready_q  <= 1'b1;
              load_busy_q  <= 1'b0;
            end
          end
        end
        ST_RUN: begin
          if (load_start_i) begin
            state_q      <= ST_LOAD;
            ptr_q        <= '0;
            load_ready_q <= 1'b1;
            req_ready_q  <= 1'b0;
            load_busy_q  <= 1'b1;
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          ptr_q        <= '0;
          req_ready_q  <= 1'b0;
          load_ready_q <= 1'b0;
          load_busy_q  <= 1'b1;
        end
      endcase
    end
  end

  // Image write port: one word per accepted load beat. RAM contents are not
  // reset. Loads and fetches are accepted in different states, so a word is
  // never written and read in the same cycle.
  always_ff @(posedge clk) begin
    if (load_accept_s) begin
      mem_q[ptr_q[IDX_W-1:0]] <= load_data_i;
    end
  end

  // Registered fetch response. Data and fault hold their values while no
  // response is issued. A faulting fetch does not read the RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid_q <= 1'b0;
      resp_fault_q <= 1'b0;
      resp_instr_q <= NOP_INSTR;
    end else begin
      resp_valid_q <= resp_valid_d;
      if (resp_valid_d) begin
        resp_fault_q <= fault_s;
        if (fault_s) begin
          resp_instr_q <= NOP_INSTR;
        end else begin
          resp_instr_q <= mem_q[idx_s];
        end
      end
    end
  end

  assign req_ready_o  = req_ready_q;
  assign load_ready_o = load_ready_q;
  assign load_busy_o  = load_busy_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_fault_o = resp_fault_q;
  assign resp_instr_o = resp_instr_q;

endmodule

// File: tb/tb_imem_responder.sv
// -----------------------------------------------------------------------------
// tb_imem_responder
//
// Directed, self-checking bench for imem_responder.
//
// Inputs are driven 1 ns after each rising edge. Outputs are sampled at that
// same point, so every sample reflects the registers updated on the
// preceding edge.
// -----------------------------------------------------------------------------
module tb_imem_responder;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 4096;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  localparam logic [31:0] WA = 32'h0011_2233;
  localparam logic [31:0] WB = 32'h4455_6677;
  localparam logic [31:0] WC = 32'h8899_AABB;
  localparam logic [31:0] WD = 32'hDEAD_0000;
  localparam logic [31:0] WE = 32'hBEEF_0001;
  localparam logic [31:0] WF = 32'hF00D_CAFE;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        flush;
  logic        resp_valid;
  logic [31:0] resp_instr;
  logic        resp_fault;
  logic        load_start;
  logic        load_valid;
  logic        load_ready;
  logic [31:0] load_data;
  logic        load_last;
  logic        load_busy;

  int n_checks = 0;
  int n_fail   = 0;

  imem_responder #(
    .BASE_ADDR  (BASE),
    .DEPTH_WORDS(DEPTH),
    .NOP_INSTR  (NOP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_addr_i  (req_addr),
    .flush_i     (flush),
    .resp_valid_o(resp_valid),
    .resp_instr_o(resp_instr),
    .resp_fault_o(resp_fault),
    .load_start_i(load_start),
    .load_valid_i(load_valid),
    .load_ready_o(load_ready),
    .load_data_i (load_data),
    .load_last_i (load_last),
    .load_busy_o (load_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid  = 1'b0;
    req_addr   = 32'h0000_0000;
    flush      = 1'b0;
    load_start = 1'b0;
    load_valid = 1'b0;
    load_data  = 32'h0000_0000;
    load_last  = 1'b0;
  endtask

  task automatic begin_load();
    load_start = 1'b1;
    step();
    load_start = 1'b0;
  endtask

  task automatic load_word(input logic [31:0] d, input logic last);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    step();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    step();
    step();
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_req_ready: got %b expected 0", req_ready); end
    n_checks++; if (load_ready !== 1'b0) begin n_fail++; $display("FAIL rst_load_ready: got %b expected 0", load_ready); end
    n_checks++; if (load_busy !== 1'b1) begin n_fail++; $display("FAIL rst_load_busy: got %b expected 1", load_busy); end
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid: got %b expected 0", resp_valid); end
    n_checks++; if (resp_fault !== 1'b0) begin n_fail++; $display("FAIL rst_resp_fault: got %b expected 0", resp_fault); end
    n_checks++; if (resp_instr !== NOP) begin n_fail++; $display("FAIL rst_resp_instr: got %h expected %h", resp_instr, NOP); end
    rst = 1'b0;
    step();
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL idle_req_ready: got %b expected 0", req_ready); end
    n_checks++; if (load_busy !== 1'b1) begin n_fail++; $display("FAIL idle_load_busy: got %b expected 1", load_busy); end
  endtask

  task automatic test_load_and_fetch();
    begin_load();
    n_checks++; if (load_ready !== 1'b1) begin n_fail++; $display("FAIL load_entry_ready: got %b expected 1", load_ready); end
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL load_entry_req_ready: got %b expected 0", req_ready); end
    load_word(WA, 1'b0);
    load_word(WB, 1'b0);
    load_word(WC, 1'b1);
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL run_req_ready: got %b expected 1", req_ready); end
    n_checks++; if (load_ready !== 1'b0) begin n_fail++; $display("FAIL run_load_ready: got %b expected 0", load_ready); end
    n_checks++; if (load_busy !== 1'b0) begin n_fail++; $display("FAIL run_load_busy: got %b expected 0", load_busy); end
    req_valid = 1'b1;
    req_addr  = BASE;
    step();
    n_checks++; if (resp_valid !== 1'b1 || resp_instr !== WA || resp_fault !== 1'b0) begin n_fail++; $display("FAIL fetch_a: got v=%b i=%h f=%b expected v=1 i=%h f=0", resp_valid, resp_instr, resp_fault, WA); end
    req_addr = BASE + 32'd4;
    step();
    n_checks++; if (resp_valid !== 1'b1 || resp_instr !== WB || resp_fault !== 1'b0) begin n_fail++; $display("FAIL fetch_b: got v=%b i=%h f=%b expected v=1 i=%h f=0", resp_valid, resp_instr, resp_fault, WB); end
    req_addr = BASE + 32'd8;
    step();
    n_checks++; if (resp_valid !== 1'b1 || resp_instr !== WC || resp_fault !== 1'b0) begin n_fail++; $display("FAIL fetch_c: got v=%b i=%h f=%b expected v=1 i=%h f=0", resp_valid, resp_instr, resp_fault, WC); end
    req_valid = 1'b0;
    step();
    n_checks++; if (resp_valid !== 1'b0 || resp_instr !== WC) begin n_fail++; $display("FAIL resp_hold: got v=%b i=%h expected v=0 i=%h", resp_valid, resp_instr, WC); end
  endtask

  task automatic test_fault();
    req_valid = 1'b1;
    req_addr  = 32'h8000_0002;
    step();
    n_checks++; if (resp_valid !== 1'b1 || resp_fault !== 1'b1 || resp_instr !== NOP) begin n_fail++; $display("FAIL misaligned: got v=%b f=%b i=%h expected v=1 f=1 i=%h", resp_valid, resp_fault, resp_instr, NOP); end
    req_addr = 32'h7FFF_FFFC;
    step();
    n_checks++; if (resp_valid !== 1'b1 || resp_fault !== 1'b1 || resp_instr !== NOP) begin n_fail++; $display("FAIL below_base: got v=%b f=%b i=%h expected v=1 f=1 i=%h", resp_valid, resp_fault, resp_instr, NOP); end
    req_addr = 32'h8000_4000;
    step();
    n_checks++; if (resp_valid !== 1'b1 || resp_fault !== 1'b1 || resp_instr !== NOP) begin n_fail++; $display("FAIL past_end: got v=%b f=%b i=%h expected v=1 f=1 i=%h", resp_valid, resp_fault, resp_instr, NOP); end
    req_addr = 32'h8000_3FFC;
    step();
    n_checks++; if (resp_valid !== 1'b1 || resp_fault !== 1'b0) begin n_fail++; $display("FAIL last_word_in_range: got v=%b f=%b expected v=1 f=0", resp_valid, resp_fault); end
    req_addr = BASE + 32'd8;
    step();
    n_checks++; if (resp_valid !== 1'b1 || resp_fault !== 1'b0 || resp_instr !== WC) begin n_fail++; $display("FAIL fault_clear: got v=%b f=%b i=%h expected v=1 f=0 i=%h", resp_valid, resp_fault, resp_instr, WC); end
    req_valid = 1'b0;
    step();
  endtask

  task automatic test_flush();
    req_valid = 1'b1;
    req_addr  = BASE;
    flush     = 1'b1;
    step();
    n_checks++; if (resp_valid !== 1'b0 || resp_instr !== WC) begin n_fail++; $display("FAIL flush_squash: got v=%b i=%h expected v=0 i=%h", resp_valid, resp_instr, WC); end
    req_addr = BASE + 32'd4;
    flush    = 1'b0;
    step();
    n_checks++; if (resp_valid !== 1'b1 || resp_instr !== WB) begin n_fail++; $display("FAIL flush_next: got v=%b i=%h expected v=1 i=%h", resp_valid, resp_instr, WB); end
    // A flush raised while a response is already on the outputs must not
    // cancel that response.
    req_addr = BASE + 32'd8;
    flush    = 1'b1;
    #1;
    n_checks++; if (resp_valid !== 1'b1 || resp_instr !== WB) begin n_fail++; $display("FAIL flush_keeps_resp: got v=%b i=%h expected v=1 i=%h", resp_valid, resp_instr, WB); end
    step();
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL flush_squash2: got v=%b expected 0", resp_valid); end
    req_valid = 1'b0;
    flush     = 1'b0;
    step();
  endtask

  task automatic test_full_load();
    logic exp_rdy;
    begin_load();
    for (int i = 0; i < DEPTH + 2; i++) begin
      load_valid = 1'b1;
      load_data  = 32'hA500_0000 + 32'(i);
      load_last  = 1'b0;
      exp_rdy    = (i < DEPTH);
      n_checks++; if (load_ready !== exp_rdy) begin n_fail++; $display("FAIL full_load_ready[%0d]: got %b expected %b", i, load_ready, exp_rdy); end
      step();
    end
    load_valid = 1'b0;
    n_checks++; if (req_ready !== 1'b1 || load_busy !== 1'b0) begin n_fail++; $display("FAIL full_load_run: got rr=%b busy=%b expected rr=1 busy=0", req_ready, load_busy); end
    req_valid = 1'b1;
    req_addr  = BASE + 32'(4 * (DEPTH - 1));
    step();
    n_checks++; if (resp_valid !== 1'b1 || resp_fault !== 1'b0 || resp_instr !== 32'hA500_0FFF) begin n_fail++; $display("FAIL full_load_last: got v=%b f=%b i=%h expected v=1 f=0 i=a5000fff", resp_valid, resp_fault, resp_instr); end
    req_addr = BASE;
    step();
    n_checks++; if (resp_valid !== 1'b1 || resp_instr !== 32'hA500_0000) begin n_fail++; $display("FAIL full_load_first: got v=%b i=%h expected v=1 i=a5000000", resp_valid, resp_instr); end
    req_valid = 1'b0;
    step();
  endtask

  task automatic test_reload_mid_run();
    req_valid  = 1'b1;
    req_addr   = BASE + 32'd4;
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    n_checks++; if (resp_valid !== 1'b1 || resp_instr !== 32'hA500_0001) begin n_fail++; $display("FAIL reload_resp: got v=%b i=%h expected v=1 i=a5000001", resp_valid, resp_instr); end
    n_checks++; if (req_ready !== 1'b0 || load_ready !== 1'b1 || load_busy !== 1'b1) begin n_fail++; $display("FAIL reload_state: got rr=%b lr=%b busy=%b expected 0 1 1", req_ready, load_ready, load_busy); end
    req_addr = BASE;
    load_word(WD, 1'b0);
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reload_no_accept: got v=%b expected 0", resp_valid); end
    load_word(WE, 1'b1);
    n_checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL reload_done: got v=%b rr=%b expected v=0 rr=1", resp_valid, req_ready); end
    step();
    n_checks++; if (resp_valid !== 1'b1 || resp_instr !== WD) begin n_fail++; $display("FAIL reload_d: got v=%b i=%h expected v=1 i=%h", resp_valid, resp_instr, WD); end
    req_addr = BASE + 32'd4;
    step();
    n_checks++; if (resp_valid !== 1'b1 || resp_instr !== WE) begin n_fail++; $display("FAIL reload_e: got v=%b i=%h expected v=1 i=%h", resp_valid, resp_instr, WE); end
    req_valid = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    req_valid  = 1'b1;
    req_addr   = BASE + 32'd4;
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    req_valid  = 1'b0;
    n_checks++; if (resp_valid !== 1'b1 || resp_instr !== WE) begin n_fail++; $display("FAIL pending_resp: got v=%b i=%h expected v=1 i=%h", resp_valid, resp_instr, WE); end
    rst = 1'b1;
    #1;
    n_checks++; if (resp_valid !== 1'b0 || resp_instr !== NOP) begin n_fail++; $display("FAIL midrst_resp: got v=%b i=%h expected v=0 i=%h", resp_valid, resp_instr, NOP); end
    n_checks++; if (load_busy !== 1'b1 || load_ready !== 1'b0 || req_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_state: got busy=%b lr=%b rr=%b expected 1 0 0", load_busy, load_ready, req_ready); end
    step();
    rst        = 1'b0;
    req_valid  = 1'b1;
    req_addr   = BASE;
    load_valid = 1'b1;
    load_data  = WA;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (req_ready !== 1'b0 || resp_valid !== 1'b0 || load_ready !== 1'b0) begin n_fail++; $display("FAIL post_rst_idle[%0d]: got rr=%b v=%b lr=%b expected 0 0 0", i, req_ready, resp_valid, load_ready); end
    end
    load_valid = 1'b0;
    req_valid  = 1'b0;
    begin_load();
    load_word(WF, 1'b1);
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_run: got rr=%b expected 1", req_ready); end
    req_valid = 1'b1;
    req_addr  = BASE;
    step();
    n_checks++; if (resp_valid !== 1'b1 || resp_instr !== WF) begin n_fail++; $display("FAIL post_rst_fetch: got v=%b i=%h expected v=1 i=%h", resp_valid, resp_instr, WF); end
    req_valid = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_load_and_fetch();
    test_fault();
    test_flush();
    test_full_load();
    test_reload_mid_run();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
